// File: rtl/mem_access_unit.sv
// Purpose : initiator side of the CPU data-memory port; alignment check, loads, read-modify-write stores.
// Latency : misaligned C+1, load C+2, word store C+2, byte/half store C+3 (request accepted in cycle C).
// Backpress: req_ready high only in IDLE; requests seen while busy are ignored and must be held.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_*                       request handshake (valid/ready), access type, address, store data
//   resp_valid/rdata/err        one-cycle response pulse; rdata/err hold until the next response
//   err_count                   saturating count of misaligned requests
//   mem_*                       combinational-read / whole-word-write data memory port
module mem_access_unit #(
  parameter int ADDR_W   = 9,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic                req_half,
  input  logic                req_byte,
  input  logic                req_uns,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  output logic                mem_half,
  output logic                mem_byte,
  output logic                mem_uns,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, MERGE, WRITE} state_t;

  state_t state, state_nxt;

  // Latched request. The store flag is carried by the state itself, and only
  // the low halfword of store data is needed after acceptance (word stores
  // go straight into wbuf).
  logic              lat_half;
  logic              lat_byte;
  logic              lat_uns;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [31:0]       wbuf;

  logic              misaligned;
  logic [31:0]       merged;

  // half has priority over byte; neither means word
  assign misaligned = req_half ? req_addr[0]
                               : (!req_byte && (req_addr[1:0] != 2'b00));

  // Big-endian lane replacement: byte 0 of a word is bits [31:24].
  always_comb begin
    merged = mem_rdata;
    if (lat_half) begin
      if (lat_addr[1]) merged[15:0]  = lat_wdata;
      else             merged[31:16] = lat_wdata;
    end else begin
      case (lat_addr[1:0])
        2'd0:    merged[31:24] = lat_wdata[7:0];
        2'd1:    merged[23:16] = lat_wdata[7:0];
        2'd2:    merged[15:8]  = lat_wdata[7:0];
        default: merged[7:0]   = lat_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_addr  = '0;
    mem_half  = 1'b0;
    mem_byte  = 1'b0;
    mem_uns   = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !misaligned) begin
          if (!req_store)                state_nxt = LOAD;
          else if (req_half || req_byte) state_nxt = MERGE;
          else                           state_nxt = WRITE;
        end
      end
      LOAD: begin
        mem_addr  = lat_addr;
        mem_half  = lat_half;
        mem_byte  = lat_byte;
        mem_uns   = lat_uns;
        state_nxt = IDLE;
      end
      MERGE: begin
        // full-word read of the containing word (select controls left at 0)
        mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
        state_nxt = WRITE;
      end
      default: begin // WRITE
        mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = wbuf;
        state_nxt = IDLE;
      end
    endcase
  end

  // Gated by rst so a reset landing on a WRITE cycle never corrupts memory.
  assign mem_we = (state == WRITE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_half   <= 1'b0;
      lat_byte   <= 1'b0;
      lat_uns    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      wbuf       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_half  <= req_half;
            lat_byte  <= req_byte;
            lat_uns   <= req_uns;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata[15:0];
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              if (err_count != '1) err_count <= err_count + 1'b1;
            end else if (req_store && !req_half && !req_byte) begin
              wbuf <= req_wdata;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= mem_rdata;
        end
        MERGE: begin
          wbuf <= merged;
        end
        default: begin // WRITE
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU data-memory interface. Sits between the pipeline MEM stage and the byte-addressed, big-endian, 512-byte data memory.
- The memory reads combinationally with byte/half/word select and sign extension. It writes only whole aligned words, on the rising clock edge.
- This block accepts load/store requests with a valid/ready handshake and checks alignment.
- It does read-modify-write for byte and halfword stores and returns a registered response.

Parameters:
- ADDR_W, 9, byte address width (512 B space)
- ERRCNT_W, 8, width of the saturating misalignment counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_store  in  1  1=store, 0=load
- req_half  in  1  halfword access
- req_byte  in  1  byte access (req_half has priority); both 0 = word
- req_uns  in  1  zero-extend load instead of sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified for byte/half
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  misaligned access; no memory write occurred
- err_count  out  ERRCNT_W  saturating count of misaligned requests
- mem_addr  out  ADDR_W  address to data memory
- mem_we  out  1  whole-word write enable to data memory
- mem_wdata  out  32  word to write
- mem_half, mem_byte, mem_uns  out  1 each  read-select controls to data memory
- mem_rdata  in  32  combinational read data from data memory

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, err_count=0; latched request cleared.
  - mem_we is gated by !rst, so no memory write happens in any cycle where rst is high, even mid-store.
- States:
  - IDLE: req_ready=1. On req_valid, latch store/half/byte/uns/addr/wdata.
  - LOAD: one memory-read cycle.
  - MERGE: read the aligned word for a partial store.
  - WRITE: single-cycle write.
- Alignment check in IDLE: misaligned = half&addr[0] | word&(addr[1:0]!=0).
  - If misaligned: state stays IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0; err_count += 1, saturating at all-ones.
- IDLE transitions (non-misaligned):
  - load -> LOAD
  - word store -> WRITE, with wbuf = req_wdata
  - byte/half store -> MERGE
- Memory outputs:
  - mem_addr = latched addr in LOAD; = {addr[8:2],2'b00} in MERGE/WRITE; 0 in IDLE.
  - mem_half/mem_byte/mem_uns = latched flags in LOAD; 0 in all other states (MERGE reads a full word).
  - mem_we = (state==WRITE) & !rst; mem_wdata = wbuf in WRITE, else 0.
- LOAD: capture mem_rdata into resp_rdata; resp_valid=1, resp_err=0 the next cycle; -> IDLE.
- MERGE: wbuf = mem_rdata with one lane replaced (big-endian); -> WRITE.
  - Byte, addr[1:0]=0/1/2/3 -> bits [31:24]/[23:16]/[15:8]/[7:0] replaced by wdata[7:0].
  - Half, addr[1]=0/1 -> bits [31:16]/[15:0] replaced by wdata[15:0].
- WRITE: memory updates at the edge ending this cycle; next cycle resp_valid=1, resp_rdata=0; -> IDLE.
- Latency, request accepted in cycle C, response cycle:
  - misaligned: C+1
  - load: C+2
  - word store: C+2
  - byte/half store: C+3
- req_ready is high in the response cycle, so back-to-back requests are allowed.
- resp_valid is exactly one cycle. resp_rdata and resp_err hold until the next response or reset.
- Requests presented while req_ready=0 are ignored; the initiator must hold them.

Test Plan:
- Bench memory word 0x08=0x00008002. Load byte at 0x0a signed -> resp_rdata=0xFFFFFF80 at C+2; with req_uns=1 -> 0x00000080.
- Load half at 0x0a signed -> 0xFFFF8002. Load word at 0x08 -> 0x00008002. resp_err=0 in all cases.
- Store byte 0x5A to 0x09 on word 0x00008002 -> one mem_we pulse at C+2, word becomes 0x005A8002. Reloading the word returns 0x005A8002.
- Store half to 0x09 and word to 0x0a -> resp_err=1 at C+1, no mem_we ever, err_count=2. 300 misaligned requests -> err_count saturates at 255.
- Word store 0x12345678 to 0x10, next-cycle-issued load of 0x10 -> store resp at C+2, load resp 0x12345678 two cycles later. req_ready is high in the store's response cycle.
- rst asserted during a byte-store WRITE cycle -> mem_we=0 that cycle, memory unchanged. Next cycle: state IDLE, req_ready=1, resp_valid=0, err_count=0.
